// File: rtl/hififo_csr_bank_if.sv
// PIO bus between the PCIe RX/TX glue and the hififo CSR bank.
//   wr_valid / rd_valid : one-cycle write / read strobes
//   address             : word address, ADDR_W bits
//   wdata               : 64-bit write data
//   rc_data / rc_done   : read-completion data and strobe, one cycle after rd_valid
// master = PIO requester, slave = register bank.
interface hififo_csr_bank_if #(
    parameter int unsigned ADDR_W = 13
);
    logic              wr_valid;
    logic              rd_valid;
    logic [ADDR_W-1:0] address;
    logic [63:0]       wdata;
    logic [63:0]       rc_data;
    logic              rc_done;

    modport master (
        output wr_valid, rd_valid, address, wdata,
        input  rc_data, rc_done
    );

    modport slave (
        input  wr_valid, rd_valid, address, wdata,
        output rc_data, rc_done
    );
endinterface

// File: rtl/hififo_csr_bank.sv
// Control/status register bank for the hififo PCIe endpoint, serving NCH FIFO channels.
// Decodes PIO reads/writes, returns read completions, merges per-channel interrupt lines
// into one maskable sticky status with a one-cycle interrupt pulse, and stretches
// per-channel FIFO resets.
// Ports:
//   clock, reset  : core clock, synchronous active-high reset
//   bus (slave)   : PIO write/read requests and read completions
//   irq_in        : NCH*IRQ_PER_CH interrupt lines, bit ch*IRQ_PER_CH+k
//   ch_status     : per-channel 64-bit status words, channel n at [64n+63:64n]
//   ch_reset      : per-channel FIFO reset, active-high
//   interrupt_out : one-cycle interrupt request pulse
// Address map (64-bit words): 0 STATUS (R, W1C), 1 COUNT, 2 MASK, 3 RESETCTL, 4+n STATUSn.
module hififo_csr_bank #(
    parameter int unsigned NCH           = 2,
    parameter int unsigned IRQ_PER_CH    = 2,
    parameter int unsigned ADDR_W        = 13,
    parameter int unsigned COUNT_W       = 32,
    parameter int unsigned RESET_CYCLES  = 16,
    parameter bit          IRQ_EDGE      = 1'b0,
    parameter bit          CLEAR_ON_READ = 1'b1
) (
    input  logic                       clock,
    input  logic                       reset,
    hififo_csr_bank_if.slave           bus,
    input  logic [NCH*IRQ_PER_CH-1:0]  irq_in,
    input  logic [NCH*64-1:0]          ch_status,
    output logic [NCH-1:0]             ch_reset,
    output logic                       interrupt_out
);
    localparam int unsigned NI     = NCH * IRQ_PER_CH;
    localparam int unsigned RCNT_W = $clog2(RESET_CYCLES + 1);
    localparam logic [RCNT_W-1:0] RCNT_LOAD = RCNT_W'(RESET_CYCLES);

    logic [NI-1:0]      status_q, status_d;
    logic [NI-1:0]      mask_q;
    logic [NI-1:0]      irq_prev_q;
    logic [NI-1:0]      irq_event;
    logic [NI-1:0]      clr;
    logic [NI-1:0]      wmask;
    logic [COUNT_W-1:0] count_q;
    logic [RCNT_W-1:0]  rcnt_q [NCH];
    logic [63:0]        rc_data_q;
    logic [63:0]        rd_word;
    logic               rc_done_q;
    logic               interrupt_q;
    logic               irq_d;
    logic               wr_status, wr_mask, wr_resetctl, rd_status;
    logic               unused_wdata;

    // Upper write-data bits have no destination in this bank.
    assign unused_wdata = ^bus.wdata;

    always_comb begin
        wr_status   = bus.wr_valid && (bus.address == ADDR_W'(0));
        wr_mask     = bus.wr_valid && (bus.address == ADDR_W'(2));
        wr_resetctl = bus.wr_valid && (bus.address == ADDR_W'(3));
        rd_status   = bus.rd_valid && (bus.address == ADDR_W'(0));
        wmask       = bus.wdata[NI-1:0];

        irq_event = IRQ_EDGE ? (irq_in & ~irq_prev_q) : (irq_in ^ irq_prev_q);

        // Clear-on-read clears exactly the bits being returned; a new event this cycle
        // is OR-ed in afterwards so it is never lost.
        clr = (wr_status ? wmask : '0) | ((CLEAR_ON_READ && rd_status) ? status_q : '0);
        status_d = (status_q & ~clr) | irq_event;

        // Unmasking an already-pending bit re-signals it.
        irq_d = (|(mask_q & irq_event)) || (wr_mask && (|(wmask & ~mask_q & status_q)));
    end

    always_comb begin
        for (int n = 0; n < NCH; n++) begin
            ch_reset[n] = (rcnt_q[n] != '0);
        end
    end

    // Read mux works on pre-update state, so same-cycle writes/clears are not visible.
    always_comb begin
        rd_word = '0;
        case (bus.address)
            ADDR_W'(0): rd_word[NI-1:0]      = status_q;
            ADDR_W'(1): rd_word[COUNT_W-1:0] = count_q;
            ADDR_W'(2): rd_word[NI-1:0]      = mask_q;
            ADDR_W'(3): rd_word[NCH-1:0]     = ch_reset;
            default: begin
                for (int n = 0; n < NCH; n++) begin
                    if (bus.address == ADDR_W'(n + 4)) begin
                        rd_word = ch_status[64*n +: 64];
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            status_q    <= '0;
            mask_q      <= '0;
            irq_prev_q  <= '0;
            count_q     <= '0;
            rc_data_q   <= '0;
            rc_done_q   <= 1'b0;
            interrupt_q <= 1'b0;
            for (int n = 0; n < NCH; n++) begin
                rcnt_q[n] <= RCNT_LOAD;
            end
        end else begin
            status_q    <= status_d;
            irq_prev_q  <= irq_in;
            count_q     <= count_q + COUNT_W'(1);
            interrupt_q <= irq_d;
            rc_done_q   <= bus.rd_valid;
            if (wr_mask) begin
                mask_q <= wmask;
            end
            if (bus.rd_valid) begin
                rc_data_q <= rd_word;
            end
            // Reload wins over countdown, so a repeat request restarts the full length.
            for (int n = 0; n < NCH; n++) begin
                if (wr_resetctl && bus.wdata[n]) begin
                    rcnt_q[n] <= RCNT_LOAD;
                end else if (rcnt_q[n] != '0) begin
                    rcnt_q[n] <= rcnt_q[n] - RCNT_W'(1);
                end
            end
        end
    end

    assign bus.rc_data    = rc_data_q;
    assign bus.rc_done    = rc_done_q;
    assign interrupt_out  = interrupt_q;
endmodule
